parallel_buffer_stage: RTL and testbench

- Valid/ready register slice (skid-less pipeline buffer) that holds one WIDTH-bit word per stage.
- DEPTH stages are chained internally.
- Sits between a producer (data_in/write_in/write_ready) and a consumer (data_out/write_out/next_ready) to break timing paths.
- Multiple instances can also be chained externally, with write_out driving the next instance's write_in and write_ready driving the previous instance's next_ready.

---
 rtl/parallel_buffer_pkg.sv | 14 +
 rtl/parallel_buffer_stage_if.sv | 31 +++
 rtl/parallel_buffer_cell.sv | 55 +++++
 rtl/parallel_buffer_stage.sv | 104 ++++++++++
 tb/tb_parallel_buffer_stage.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/parallel_buffer_pkg.sv
// Shared definitions for the parallel_buffer_stage register slice.
// Optional feature macro: PARALLEL_BUFFER_LEVEL_EN (adds the level output).
package parallel_buffer_pkg;

  // Default data word width for the slice and its interface.
  localparam int PB_WIDTH_DEFAULT = 8;

  // Width of the occupancy count for a chain of 'depth' stages.
  // Counts 0..depth inclusive, so it needs clog2(depth+1) bits.
  function automatic int level_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/parallel_buffer_stage_if.sv
// Valid/ready word channel used on both sides of parallel_buffer_stage.
// Optional feature macro of the slice: PARALLEL_BUFFER_LEVEL_EN (not used here).
//
// Handshake: a word transfers at a rising edge when write && ready are both 1.
// While write=1 and ready=0 the master must hold data and write unchanged;
// ready may depend combinationally on the downstream side, never on write.
interface parallel_buffer_stage_if
  import parallel_buffer_pkg::*;
#(
  parameter int WIDTH = PB_WIDTH_DEFAULT
);

  logic [WIDTH-1:0] data;   // word offered by the master
  logic             write;  // data is valid
  logic             ready;  // slave accepts data at the next rising edge

  // Producer side of a channel.
  modport master (
    output data,
    output write,
    input  ready
  );

  // Consumer side of a channel.
  modport slave (
    input  data,
    input  write,
    output ready
  );

endinterface

// File: rtl/parallel_buffer_cell.sv
// One full/data register stage of the parallel buffer chain.
// Optional feature macro of the slice: PARALLEL_BUFFER_LEVEL_EN (not used here).
//
// The stage is ready when it is empty or when the stage after it is ready,
// so a full stage can hand its word on and capture a new one in one edge.
module parallel_buffer_cell
  import parallel_buffer_pkg::*;
#(
  parameter int WIDTH = PB_WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             valid_i,       // word offered by the previous stage
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_next_i,  // next stage (or consumer) ready
  output logic             ready_o,       // this stage accepts data_i
  output logic             full_o,        // this stage holds a valid word
  output logic [WIDTH-1:0] data_o
);

  logic             full_q;
  logic             full_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Ready ripples back from the consumer; empty stages are always ready.
  assign ready_o = !full_q || ready_next_i;

  // Next-state: capture on accept, empty on drain-only, otherwise hold.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (valid_i && ready_o) begin
      data_d = data_i;
      full_d = 1'b1;
    end else if (ready_next_i) begin
      full_d = 1'b0;
    end
  end

  // Stage registers; data keeps its last value when the stage empties.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/parallel_buffer_stage.sv
// Valid/ready register slice built from DEPTH chained one-word stages.
// Breaks timing paths between producer and consumer: data_out and write_out
// come straight from the last stage's registers. write_ready is combinational
// through the ready chain so a full chain with a ready consumer still streams
// one word per cycle.
// Optional feature macro: PARALLEL_BUFFER_LEVEL_EN adds the 'level' output,
// a registered count of occupied stages.
module parallel_buffer_stage
  import parallel_buffer_pkg::*;
#(
  parameter int WIDTH = PB_WIDTH_DEFAULT,
  parameter int DEPTH = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  // Producer side: up.data = data_in, up.write = write_in, up.ready = write_ready
  parallel_buffer_stage_if.slave  up,
  // Consumer side: dn.data = data_out, dn.write = write_out, dn.ready = next_ready
  parallel_buffer_stage_if.master dn
`ifdef PARALLEL_BUFFER_LEVEL_EN
  ,
  output logic [level_w(DEPTH)-1:0] level
`endif
);

  // Stage chain: stage 0 faces the producer, stage DEPTH-1 the consumer.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             valid_in_w;
    logic [WIDTH-1:0] data_in_w;
    logic             ready_next_w;
    logic             ready_w;
    logic             full_w;
    logic [WIDTH-1:0] data_w;

    // Forward path: stage k takes the previous stage's registered word.
    if (k == 0) begin : g_head
      assign valid_in_w = up.write;
      assign data_in_w  = up.data;
    end else begin : g_link
      assign valid_in_w = g_stage[k-1].full_w;
      assign data_in_w  = g_stage[k-1].data_w;
    end

    // Backward path: ready comes from the next stage or from the consumer.
    if (k == DEPTH - 1) begin : g_tail
      assign ready_next_w = dn.ready;
    end else begin : g_mid
      assign ready_next_w = g_stage[k+1].ready_w;
    end

    parallel_buffer_cell #(
      .WIDTH (WIDTH)
    ) u_cell (
      .clock        (clock),
      .reset_n      (reset_n),
      .valid_i      (valid_in_w),
      .data_i       (data_in_w),
      .ready_next_i (ready_next_w),
      .ready_o      (ready_w),
      .full_o       (full_w),
      .data_o       (data_w)
    );
  end

  assign up.ready = g_stage[0].ready_w;
  assign dn.write = g_stage[DEPTH-1].full_w;
  assign dn.data  = g_stage[DEPTH-1].data_w;

`ifdef PARALLEL_BUFFER_LEVEL_EN
  localparam int LW = level_w(DEPTH);

  logic          accept_w;
  logic          drain_w;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;

  assign accept_w = up.write && g_stage[0].ready_w;
  assign drain_w  = g_stage[DEPTH-1].full_w && dn.ready;

  // Occupancy moves only when exactly one of accept/drain happens.
  always_comb begin
    level_d = level_q;
    case ({accept_w, drain_w})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Occupancy register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign level = level_q;
`else
  // Without the level feature the slice carries no occupancy counter.
`endif

endmodule

// File: tb/tb_parallel_buffer_stage.sv
// Bench for parallel_buffer_stage: a cascade of two DEPTH=1 slices and one
// DEPTH=4 slice, each checked against a slot-array reference model and a
// word-order scoreboard.
module tb_parallel_buffer_stage;
  import parallel_buffer_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUTs ----------------
  parallel_buffer_stage_if #(.WIDTH(W)) a_up ();
  parallel_buffer_stage_if #(.WIDTH(W)) a_mid ();
  parallel_buffer_stage_if #(.WIDTH(W)) a_dn ();
  parallel_buffer_stage_if #(.WIDTH(W)) b_up ();
  parallel_buffer_stage_if #(.WIDTH(W)) b_dn ();

`ifdef PARALLEL_BUFFER_LEVEL_EN
  logic [level_w(1)-1:0] a0_level;
  logic [level_w(1)-1:0] a1_level;
  logic [level_w(4)-1:0] b_level;
`endif

  parallel_buffer_stage #(.WIDTH(W), .DEPTH(1)) u_a0 (
    .clock   (clock),
    .reset_n (reset_n),
    .up      (a_up),
    .dn      (a_mid)
`ifdef PARALLEL_BUFFER_LEVEL_EN
    , .level (a0_level)
`endif
  );

  parallel_buffer_stage #(.WIDTH(W), .DEPTH(1)) u_a1 (
    .clock   (clock),
    .reset_n (reset_n),
    .up      (a_mid),
    .dn      (a_dn)
`ifdef PARALLEL_BUFFER_LEVEL_EN
    , .level (a1_level)
`endif
  );

  parallel_buffer_stage #(.WIDTH(W), .DEPTH(4)) u_b (
    .clock   (clock),
    .reset_n (reset_n),
    .up      (b_up),
    .dn      (b_dn)
`ifdef PARALLEL_BUFFER_LEVEL_EN
    , .level (b_level)
`endif
  );

  // ---------------- reference model ----------------
  // Model 0: the cascade (two slots), model 1: the DEPTH=4 slice.
  // Slot d-1 faces the consumer. Each edge everything up to the last empty
  // slot moves one place toward the consumer; the full run behind it stays.
  // With the consumer ready the whole chain moves.
  bit         mv[2][4];
  logic [W-1:0] md[2][4];
  int         mdep[2];

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic m_reset();
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < 4; k++) begin
        mv[m][k] = 1'b0;
        md[m][k] = '0;
      end
    qa.delete();
    qb.delete();
  endtask

  function automatic int m_count(input int m);
    int c = 0;
    for (int k = 0; k < mdep[m]; k++) c += int'(mv[m][k]);
    return c;
  endfunction

  function automatic bit m_wready(input int m, input bit nr);
    return !((m_count(m) == mdep[m]) && !nr);
  endfunction

  task automatic m_step(input int m, input bit wr, input logic [W-1:0] din, input bit nr);
    int h = -1;
    for (int k = 0; k < mdep[m]; k++) if (!mv[m][k]) h = k;
    if (nr) h = mdep[m] - 1;
    if (h >= 0) begin
      for (int k = h; k >= 1; k--) begin
        mv[m][k] = mv[m][k-1];
        if (mv[m][k-1]) md[m][k] = md[m][k-1];
      end
      mv[m][0] = wr;
      if (wr) md[m][0] = din;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_a();
    chk("a_wout", a_dn.write, mv[0][1]);
    chk("a_mid_wout", a_mid.write, mv[0][0]);
    chk("a_wready", a_up.ready, m_wready(0, a_dn.ready));
    if (mv[0][1]) chk("a_dout", a_dn.data, md[0][1]);
`ifdef PARALLEL_BUFFER_LEVEL_EN
    chk("a0_level", a0_level, mv[0][0]);
    chk("a1_level", a1_level, mv[0][1]);
`endif
  endtask

  task automatic cmp_b();
    chk("b_wout", b_dn.write, mv[1][3]);
    chk("b_wready", b_up.ready, m_wready(1, b_dn.ready));
    if (mv[1][3]) chk("b_dout", b_dn.data, md[1][3]);
`ifdef PARALLEL_BUFFER_LEVEL_EN
    chk("b_level", b_level, m_count(1));
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Drive at the falling edge, check pre-edge state, then run the scoreboard.
  task automatic set_a(input bit wr, input logic [W-1:0] d, input bit nr);
    @(negedge clock);
    a_up.write = wr;
    a_up.data  = d;
    a_dn.ready = nr;
    #1;
    cmp_a();
    if (mv[0][1] && nr) begin
      chk("a_sb_nonempty", qa.size() != 0, 1'b1);
      if (qa.size() != 0) chk("a_sb_data", a_dn.data, qa.pop_front());
    end
    if (wr && m_wready(0, nr)) qa.push_back(d);
  endtask

  task automatic edge_a();
    @(posedge clock);
    m_step(0, a_up.write, a_up.data, a_dn.ready);
    #1;
  endtask

  task automatic set_b(input bit wr, input logic [W-1:0] d, input bit nr);
    @(negedge clock);
    b_up.write = wr;
    b_up.data  = d;
    b_dn.ready = nr;
    #1;
    cmp_b();
    if (mv[1][3] && nr) begin
      chk("b_sb_nonempty", qb.size() != 0, 1'b1);
      if (qb.size() != 0) chk("b_sb_data", b_dn.data, qb.pop_front());
    end
    if (wr && m_wready(1, nr)) qb.push_back(d);
  endtask

  task automatic edge_b();
    @(posedge clock);
    m_step(1, b_up.write, b_up.data, b_dn.ready);
    #1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    mdep[0] = 2;
    mdep[1] = 4;
    a_up.write = 1'b0; a_up.data = '0; a_dn.ready = 1'b0;
    b_up.write = 1'b0; b_up.data = '0; b_dn.ready = 1'b0;
    m_reset();

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_a_wout", a_dn.write, 1'b0);
    chk("rst_a_dout", a_dn.data, 8'h00);
    chk("rst_a_wready", a_up.ready, 1'b1);
    chk("rst_b_wout", b_dn.write, 1'b0);
    chk("rst_b_dout", b_dn.data, 8'h00);
    chk("rst_b_wready", b_up.ready, 1'b1);
    @(negedge clock);
    reset_n = 1'b1;

    // Idle over four edges
    for (int i = 0; i < 4; i++) begin
      set_a(1'b0, 8'h00, 1'b0);
      edge_a();
      chk("idle_wready", a_up.ready, 1'b1);
      chk("idle_wout", a_dn.write, 1'b0);
    end

    // Cascade: 0x04 then 0x02 with consumer stalled
    set_a(1'b1, 8'h04, 1'b0);
    edge_a();
    set_a(1'b1, 8'h02, 1'b0);
    edge_a();
    chk("casc_dout", a_dn.data, 8'h04);
    chk("casc_wout", a_dn.write, 1'b1);
    chk("casc_wready", a_up.ready, 1'b0);

    // Drain one: ready ripples back before the edge
    set_a(1'b0, 8'h00, 1'b1);
    chk("drain_wready_pre", a_up.ready, 1'b1);
    edge_a();
    chk("drain_dout", a_dn.data, 8'h02);
    chk("drain_wout", a_dn.write, 1'b1);
    for (int i = 0; i < 2; i++) begin
      set_a(1'b0, 8'h00, 1'b0);
      edge_a();
      chk("hold_dout", a_dn.data, 8'h02);
      chk("hold_wout", a_dn.write, 1'b1);
    end

    // Last word leaves
    set_a(1'b0, 8'h00, 1'b1);
    edge_a();
    chk("empty_wout", a_dn.write, 1'b0);
    chk("empty_wready", a_up.ready, 1'b1);

    // Async reset with a full cascade, between edges
    set_a(1'b1, 8'h5A, 1'b0);
    edge_a();
    set_a(1'b1, 8'hA5, 1'b0);
    edge_a();
    set_a(1'b0, 8'h00, 1'b0);
    chk("pre_rst_wready", a_up.ready, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_wout", a_dn.write, 1'b0);
    chk("arst_wready", a_up.ready, 1'b1);
    m_reset();
    @(negedge clock);
    reset_n = 1'b1;

    // Random traffic through the cascade
    for (int i = 0; i < 300; i++) begin
      set_a(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
      edge_a();
    end
    for (int i = 0; i < 3; i++) begin
      set_a(1'b0, 8'h00, 1'b1);
      edge_a();
    end
    chk("a_sb_drained", qa.size(), 0);

    // DEPTH=4 streaming 0x10..0x17 with consumer always ready
    for (int e = 0; e < 12; e++) begin
      set_b(e < 8, W'(8'h10 + e), 1'b1);
      edge_b();
      chk("stream_wout", b_dn.write, (e >= 3 && e < 11));
      if (e >= 3 && e < 11) chk("stream_dout", b_dn.data, 8'h10 + e - 3);
    end

    // Fill DEPTH=4 with consumer stalled
    for (int i = 0; i < 4; i++) begin
      set_b(1'b1, W'(8'h20 + i), 1'b0);
      edge_b();
    end
    chk("full_wready", b_up.ready, 1'b0);
    chk("full_dout", b_dn.data, 8'h20);
`ifdef PARALLEL_BUFFER_LEVEL_EN
    chk("full_level", b_level, 4);
`endif
    set_b(1'b1, 8'h99, 1'b0);
    edge_b();
    chk("full_ignore_dout", b_dn.data, 8'h20);
    chk("full_ignore_wout", b_dn.write, 1'b1);

    // Random traffic through DEPTH=4
    for (int i = 0; i < 400; i++) begin
      set_b(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)), $urandom_range(0, 2) != 0);
      edge_b();
    end
    for (int i = 0; i < 5; i++) begin
      set_b(1'b0, 8'h00, 1'b1);
      edge_b();
    end
    chk("b_sb_drained", qb.size(), 0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
